// File: rtl/cpu_rf_pkg.sv
// Shared CPU register-file definitions: default widths, write-back
// requester indices, the output-stage entry layout and a round-robin
// pointer helper.
package cpu_rf_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 32;
  localparam int NUM_REQ_DEF = 3;

  // Write-back requester indices
  localparam int REQ_ALU = 0;
  localparam int REQ_LD  = 1;
  localparam int REQ_VPU = 2;

  // One register-file write held in the output stage
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

  // Pointer value that follows grant g in a ring of n requesters
  function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
    if (g + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return g + 32'd1;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: starting at ptr, scan the request
// vector cyclically and grant the first asserted request (one-hot or zero).
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  int          idx;
  logic [PW-1:0] sel;
  logic        found;

  // Cyclic priority scan beginning at the pointer position
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      sel = PW'(idx);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: round-robin sharing of the single RF
// write port between the ALU, load unit and VPU, with a one-entry
// registered output stage that honours a write-port stall.
// Optional feature macro: RF_WB_ZERO_REG_EN (writes to register 0 are
// accepted but dropped instead of reaching the register file).
module rf_wb_arbiter
  import cpu_rf_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rf_we,
  output logic [ADDR_W-1:0]              rf_waddr,
  output logic [DATA_W-1:0]              rf_wdata,
  input  logic                           rf_wr_ready,
  output logic [(1<<ADDR_W)-1:0]         rf_pending
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PEND_W = 1 << ADDR_W;

  logic [PTR_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] gnt;
  logic               can_accept;
  logic               transfer;
  logic               load;
  logic [PTR_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  // Output stage can take a new write when empty or draining this cycle
  always_comb begin
    can_accept = !rf_we || rf_wr_ready;
  end

  // Grants are only visible out of reset and when the stage can accept
  always_comb begin
    if (rst_n && can_accept) begin
      req_ready = gnt;
    end else begin
      req_ready = '0;
    end
  end

  // Select the granted requester's write and decide whether it is loaded
  always_comb begin
    transfer = |req_ready;
    gnt_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        gnt_idx  = PTR_W'(i);
        sel_addr = req_addr[i];
        sel_data = req_data[i];
      end else begin
        gnt_idx = gnt_idx;
      end
    end
`ifdef RF_WB_ZERO_REG_EN
    // Register 0 is hardwired: accept the write but never forward it
    load = transfer && (sel_addr != '0);
`else
    load = transfer;
`endif
  end

  // Round-robin pointer and the registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      rf_pending <= '0;
    end else begin
      if (transfer) begin
        rr_ptr <= PTR_W'(rr_next(32'(gnt_idx), NUM_REQ));
      end else begin
        rr_ptr <= rr_ptr;
      end

      if (load) begin
        rf_we      <= 1'b1;
        rf_waddr   <= sel_addr;
        rf_wdata   <= sel_data;
        rf_pending <= {{(PEND_W-1){1'b0}}, 1'b1} << sel_addr;
      end else if (rf_we && rf_wr_ready) begin
        rf_we      <= 1'b0;
        rf_pending <= '0;
      end else begin
        rf_we      <= rf_we;
        rf_pending <= rf_pending;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter: per-requester write queues, a
// behavioural round-robin/output-stage model checked every cycle, and
// literal grant/write-order expectations per scenario.
module tb_rf_wb_arbiter;
  import cpu_rf_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [2:0]       req_valid;
  logic [2:0][4:0]  req_addr;
  logic [2:0][31:0] req_data;
  logic [2:0]       req_ready;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             rf_wr_ready;
  logic [31:0]      rf_pending;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_wr_ready (rf_wr_ready),
    .rf_pending  (rf_pending)
  );

  wb_entry_t   qs[3][$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [2:0]  act_g[$];
  logic [2:0]  exp_g[$];
  logic [31:0] act_w[$];
  logic [31:0] exp_w[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic put(input int i, input logic [4:0] a, input logic [31:0] d);
    wb_entry_t e;
    e.addr = a;
    e.data = d;
    qs[i].push_back(e);
  endtask

  task automatic eg(input logic [2:0] v);
    exp_g.push_back(v);
  endtask

  task automatic ew(input logic [31:0] v);
    exp_w.push_back(v);
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_we   = 1'b0;
    m_addr = 5'd0;
    m_data = 32'd0;
  endtask

  // Present the head of every non-empty queue
  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (qs[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_addr[i]  = qs[i][0].addr;
        req_data[i]  = qs[i][0].data;
      end else begin
        req_valid[i] = 1'b0;
        req_addr[i]  = 5'd0;
        req_data[i]  = 32'd0;
      end
    end
  endtask

  // One cycle: drive, compare against model at negedge, advance model
  task automatic step();
    logic       can;
    int         g;
    int         idx;
    logic [2:0] er;
    logic       ld;
    wb_entry_t  e;
    drive();
    @(negedge clk);
    can = !m_we || rf_wr_ready;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      idx = (m_ptr + k) % 3;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    er = (can && g >= 0) ? (3'b001 << g) : 3'b000;
    chk("req_ready", req_ready, er);
    chk("rf_we", rf_we, m_we);
    if (m_we) begin
      chk("rf_waddr", rf_waddr, m_addr);
      chk("rf_wdata", rf_wdata, m_data);
    end
    chk("rf_pending", rf_pending, m_we ? (32'd1 << m_addr) : 32'd0);
    if (req_ready != 3'b000) act_g.push_back(req_ready);
    if (rf_we && rf_wr_ready) act_w.push_back(rf_wdata);
    if (er != 3'b000) begin
      e = qs[g].pop_front();
      m_ptr = (g + 1) % 3;
      ld = 1'b1;
`ifdef RF_WB_ZERO_REG_EN
      if (e.addr == 5'd0) ld = 1'b0;
`endif
      if (ld) begin
        m_we   = 1'b1;
        m_addr = e.addr;
        m_data = e.data;
      end else if (m_we && rf_wr_ready) begin
        m_we = 1'b0;
      end
    end else if (m_we && rf_wr_ready) begin
      m_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Compare recorded grant/write order against literal expectations
  task automatic check_logs(input string tag);
    chk({tag, "_ngrant"}, act_g.size(), exp_g.size());
    chk({tag, "_nwrite"}, act_w.size(), exp_w.size());
    for (int i = 0; i < act_g.size() && i < exp_g.size(); i++)
      chk({tag, "_grant"}, act_g[i], exp_g[i]);
    for (int i = 0; i < act_w.size() && i < exp_w.size(); i++)
      chk({tag, "_write"}, act_w[i], exp_w[i]);
    act_g.delete(); exp_g.delete(); act_w.delete(); exp_w.delete();
  endtask

  initial begin
    rst_n       = 1'b0;
    rf_wr_ready = 1'b1;
    model_reset();

    // Reset with all requesters valid, then round-robin
    put(0, 5'd1, 32'h100); put(0, 5'd4, 32'h101);
    put(1, 5'd2, 32'h200); put(1, 5'd5, 32'h201);
    put(2, 5'd3, 32'h300); put(2, 5'd6, 32'h301);
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 3'b000);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_pending", rf_pending, 32'd0);
    chk("rst_rf_waddr", rf_waddr, 5'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    #2 rst_n = 1'b1;
    #1;
    repeat (8) step();
    eg(3'b001); eg(3'b010); eg(3'b100); eg(3'b001); eg(3'b010); eg(3'b100);
    ew(32'h100); ew(32'h200); ew(32'h300); ew(32'h101); ew(32'h201); ew(32'h301);
    check_logs("rr");

    // Single write from the load unit
    put(1, 5'd7, 32'hDEADBEEF);
    step();
    chk("single_we", rf_we, 1'b1);
    chk("single_waddr", rf_waddr, 5'd7);
    chk("single_wdata", rf_wdata, 32'hDEADBEEF);
    chk("single_pending", rf_pending, 32'h0000_0080);
    step(); step();
    eg(3'b010); ew(32'hDEADBEEF);
    check_logs("single");

    // Three-cycle stall with the output stage full
    put(0, 5'd9, 32'h900); put(1, 5'd10, 32'hA00); put(2, 5'd11, 32'hB00);
    step();
    rf_wr_ready = 1'b0;
    repeat (3) begin
      step();
      chk("stall_wdata", rf_wdata, 32'hB00);
      chk("stall_ready", req_ready, 3'b000);
    end
    rf_wr_ready = 1'b1;
    repeat (3) step();
    eg(3'b100); eg(3'b001); eg(3'b010);
    ew(32'hB00); ew(32'h900); ew(32'hA00);
    check_logs("stall");

    // Asynchronous reset in the middle of a stall discards the held write
    put(0, 5'd12, 32'hC00);
    step();
    rf_wr_ready = 1'b0;
    step();
    put(2, 5'd13, 32'hD00);
    drive();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_we", rf_we, 1'b0);
    chk("midrst_pending", rf_pending, 32'd0);
    chk("midrst_wdata", rf_wdata, 32'd0);
    chk("midrst_ready", req_ready, 3'b000);
    rst_n = 1'b1;
    rf_wr_ready = 1'b1;
    repeat (2) step();
    eg(3'b001); eg(3'b100); ew(32'hD00);
    check_logs("midrst");

    // Two requesters to the same register, pointer at 0
    put(0, 5'd4, 32'h11); put(2, 5'd4, 32'h22);
    repeat (3) step();
    eg(3'b001); eg(3'b100); ew(32'h11); ew(32'h22);
    check_logs("sameaddr");

    // Write to register 0
    put(0, 5'd0, 32'h55); put(1, 5'd5, 32'h66);
    step();
`ifdef RF_WB_ZERO_REG_EN
    chk("zero_we", rf_we, 1'b0);
    chk("zero_pending", rf_pending, 32'd0);
`else
    chk("zero_we", rf_we, 1'b1);
    chk("zero_waddr", rf_waddr, 5'd0);
    chk("zero_pending", rf_pending, 32'd1);
`endif
    repeat (2) step();
    eg(3'b001); eg(3'b010);
`ifndef RF_WB_ZERO_REG_EN
    ew(32'h55);
`endif
    ew(32'h66);
    check_logs("zero");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the CPU register file's single write port. Shares that port between NUM_REQ result producers (ALU, load unit, VPU move-to-scalar) using round-robin arbitration. A one-entry registered output stage drives the register file and honours a write-port stall. It sits between the execute/memory stages and the register file.

## Interface
- NUM_REQ, 3, number of requesters; index 0 = ALU, 1 = load unit, 2 = VPU
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- req_valid  input  NUM_REQ  requester i holds a write
- req_addr  input  NUM_REQ x ADDR_W  destination register per requester
- req_data  input  NUM_REQ x DATA_W  write data per requester
- req_ready  output  NUM_REQ  one-hot-or-zero; write i accepted this cycle
- rf_we  output  1  register file write enable (output stage valid)
- rf_waddr  output  ADDR_W  register file write address
- rf_wdata  output  DATA_W  register file write data
- rf_wr_ready  input  1  register file accepts the write this cycle (low = port stolen/stalled)
- rf_pending  output  2^ADDR_W  bit r set while a write to r sits in the output stage

## Operation
- Requester protocol is valid/ready. Once asserted, req_valid, req_addr and req_data stay stable until req_ready is seen. A transfer occurs when both are high.
- can_accept = !rf_we || rf_wr_ready. The output stage is empty or drains this cycle.
- Arbitration is combinational. Starting at rr_ptr, scan cyclically for the first asserted req_valid. When can_accept=1, drive that requester's req_ready=1 and all others 0. Otherwise all req_ready are 0.
- On a transfer from requester g:
  - capture {addr,data} into the output stage;
  - set rr_ptr = (g+1) mod NUM_REQ.
- rr_ptr holds when there is no transfer.
- Output stage states:
  - EMPTY: rf_we=0.
  - FULL: rf_we=1. Goes FULL→EMPTY when rf_wr_ready=1 and there is no new transfer. Stays FULL with new contents when a drain and a transfer happen in the same cycle.
- rf_pending = one-hot(rf_waddr) when rf_we=1, else all zeros. The issue stage uses it for its hazard check.
- Two requesters targeting the same register in one cycle are served in round-robin order in consecutive transfers. The later grant overwrites. No merging, no drop.
- Reset (asynchronous, any time, including mid-stall):
  - rf_we=0, rf_waddr=0, rf_wdata=0, rf_pending=0, rr_ptr=0.
  - req_ready=0 while rst_n=0.
  - A write held in the output stage is discarded.

## Timing
- Latency: transfer in cycle N → rf_we=1 with that data in cycle N+1. With rf_wr_ready=1, the write completes at the end of N+1.
- Throughput: one write per cycle while rf_wr_ready=1.
- rf_wr_ready=0 with rf_we=1:
  - output stage holds;
  - all req_ready=0;
  - rr_ptr frozen.
- When rf_wr_ready returns to 1, the held write drains and a new grant is issued in the same cycle.
- req_ready depends combinationally on req_valid, rr_ptr, rf_we and rf_wr_ready. There is no combinational path from req_addr or req_data to any output.

## Configuration
- RF_WB_ZERO_REG_EN defined:
  - a transfer addressed to register 0 is accepted (req_ready=1, rr_ptr advances) but not loaded into the output stage;
  - the output stage goes EMPTY unless it holds an undrained write;
  - rf_we never asserts for address 0.
- RF_WB_ZERO_REG_EN undefined: register 0 is written like any other register.

## Structure
- Shared package cpu_rf_pkg holds:
  - ADDR_W/DATA_W defaults;
  - the requester index constants (REQ_ALU=0, REQ_LD=1, REQ_VPU=2);
  - the output-stage struct typedef {addr, data}.
- Sub-module rr_arbiter (parameter N; inputs req[N] and ptr; output one-hot gnt). The same arbiter is reused by the VPU scheduler.

## Test plan
- Reset: hold rst_n=0 with all req_valid=1 → req_ready=0, rf_we=0, rf_pending=0. Release rst_n → first grant goes to requester 0.
- Single write: requester 1 presents addr=7, data=0xDEADBEEF in cycle N → req_ready[1]=1 in N; rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF, rf_pending[7]=1 in N+1.
- Round-robin: all three valid continuously with rf_wr_ready=1 → grants 0,1,2,0,1,2 on consecutive cycles, each visible on the write port one cycle later.
- Stall: rf_wr_ready=0 for 3 cycles with the output stage FULL → output held stable, req_ready=0, rr_ptr frozen. Release → held write completes and the next requester in order is granted the same cycle.
- Same address: requesters 0 and 2 both write register 4 (0x11, 0x22) with rr_ptr=0 → port writes 0x11 then 0x22 on consecutive cycles.
- Zero register (macro on): requester 0 writes addr=0 → req_ready[0]=1, rf_we stays 0, next grant goes to requester 1. Macro off: rf_we=1 with rf_waddr=0.
